// File: rtl/ds18b20_pkg.sv
// Shared definitions for the DS18B20 command block and its measurement sequencer:
// command codes, sequencer states, measurement steps and error codes.
package ds18b20_pkg;

    localparam logic [5:0] CMD_RESET_DETECT = 6'd1;
    localparam logic [5:0] CMD_CONVERT_T    = 6'd3;
    localparam logic [5:0] CMD_READ_SCRATCH = 6'd4;
    localparam logic [5:0] CMD_OUTPUT_TEMP  = 6'd5;
    localparam logic [5:0] CMD_POLL_WAIT    = 6'd6;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT_IRQ = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_ERROR    = 3'd4;

    typedef enum logic [2:0] {
        STEP_RESET1  = 3'd0,
        STEP_CONVERT = 3'd1,
        STEP_POLL    = 3'd2,
        STEP_RESET2  = 3'd3,
        STEP_READ    = 3'd4,
        STEP_OUTPUT  = 3'd5
    } step_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_NO_DEVICE = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;

    function automatic logic [5:0] step_cmd(input step_e s);
        case (s)
            STEP_RESET1:  return CMD_RESET_DETECT;
            STEP_CONVERT: return CMD_CONVERT_T;
            STEP_POLL:    return CMD_POLL_WAIT;
            STEP_RESET2:  return CMD_RESET_DETECT;
            STEP_READ:    return CMD_READ_SCRATCH;
            STEP_OUTPUT:  return CMD_OUTPUT_TEMP;
            default:      return CMD_RESET_DETECT;
        endcase
    endfunction

    function automatic logic is_reset_step(input step_e s);
        return (s == STEP_RESET1) || (s == STEP_RESET2);
    endfunction

endpackage

// File: rtl/ds18b20_sequencer_if.sv
// Command/completion bus between the measurement sequencer (master) and the
// DS18B20 command block (slave).
interface ds18b20_sequencer_if;
    logic [5:0]  cmd;
    logic        cmd_en;
    logic        busy;
    logic        irq;
    logic        detect;
    logic [15:0] data;

    modport master (output cmd, cmd_en, input busy, irq, detect, data);
    modport slave  (input cmd, cmd_en, output busy, irq, detect, data);
endinterface

// File: rtl/cyc_timer.sv
// Cycle counter with clear, load and count-enable (clear wins over load over
// count) and a flag that is high while the count equals TC_VAL.
module cyc_timer #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   TC_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);
endmodule

// File: rtl/ds18b20_sequencer.sv
// Runs one DS18B20 temperature measurement (reset, convert, poll, reset, read,
// output) on a manual start or a periodic timer, and latches the result.
module ds18b20_sequencer
    import ds18b20_pkg::*;
#(
    parameter int P_PERIOD_CYC  = 12_000_000,
    parameter int P_TIMEOUT_CYC = 12_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_auto,
    ds18b20_sequencer_if.master  bus,
    output logic [15:0]          o_temp_raw,
    output logic [7:0]           o_temp_int,
    output logic [3:0]           o_temp_frac,
    output logic                 o_valid,
    output logic                 o_present,
    output logic                 o_error,
    output logic [1:0]           o_err_code,
    output logic                 o_busy
);
    localparam int PER_W = (P_PERIOD_CYC  > 1) ? $clog2(P_PERIOD_CYC)  : 1;
    localparam int TO_W  = (P_TIMEOUT_CYC > 1) ? $clog2(P_TIMEOUT_CYC) : 1;

    logic [2:0]  state_q, state_d;
    step_e       step_q, step_d;
    logic [5:0]  cmd_q, cmd_d;
    logic        cmd_en_q, cmd_en_d;
    logic [15:0] temp_raw_q, temp_raw_d;
    logic        present_q, present_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        busy_q, busy_d;
    logic        per_tc, to_tc, start_evt;

    // A manual start and a timer expiry in the same cycle collapse into one start.
    assign start_evt = (state_q == ST_IDLE) && (i_start || (i_auto && per_tc));

    cyc_timer #(.W(PER_W), .TC_VAL(PER_W'(P_PERIOD_CYC - 1))) u_period (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clr      (!i_auto || start_evt || (state_q == ST_DONE) || (state_q == ST_ERROR)),
        .load     (1'b0),
        .load_val ('0),
        .en       (i_auto && (state_q == ST_IDLE)),
        .tc       (per_tc)
    );

    cyc_timer #(.W(TO_W), .TC_VAL(TO_W'(P_TIMEOUT_CYC - 1))) u_timeout (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clr      (state_q == ST_ISSUE),
        .load     (1'b0),
        .load_val ('0),
        .en       (state_q == ST_WAIT_IRQ),
        .tc       (to_tc)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cmd_d      = cmd_q;
        cmd_en_d   = 1'b0;
        temp_raw_d = temp_raw_q;
        present_d  = present_q;
        err_code_d = err_code_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start_evt) begin
                    step_d     = STEP_RESET1;
                    err_code_d = ERR_NONE;
                    busy_d     = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Holding here lets a block left mid-command by our own reset finish first.
                if (!bus.busy) begin
                    cmd_d    = step_cmd(step_q);
                    cmd_en_d = 1'b1;
                    state_d  = ST_WAIT_IRQ;
                end
            end
            ST_WAIT_IRQ: begin
                if (bus.irq) begin
                    if (is_reset_step(step_q)) begin
                        present_d = bus.detect;
                        if (!bus.detect) begin
                            err_code_d = ERR_NO_DEVICE;
                            state_d    = ST_ERROR;
                        end else begin
                            step_d  = step_e'(step_q + 3'd1);
                            state_d = ST_ISSUE;
                        end
                    end else if (step_q == STEP_OUTPUT) begin
                        temp_raw_d = bus.data;
                        state_d    = ST_DONE;
                    end else begin
                        step_d  = step_e'(step_q + 3'd1);
                        state_d = ST_ISSUE;
                    end
                end else if (to_tc) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= STEP_RESET1;
            cmd_q      <= '0;
            cmd_en_q   <= 1'b0;
            temp_raw_q <= '0;
            present_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cmd_q      <= cmd_d;
            cmd_en_q   <= cmd_en_d;
            temp_raw_q <= temp_raw_d;
            present_q  <= present_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.cmd     = cmd_q;
    assign bus.cmd_en  = cmd_en_q;
    assign o_temp_raw  = temp_raw_q;
    assign o_temp_int  = temp_raw_q[11:4];
    assign o_temp_frac = temp_raw_q[3:0];
    assign o_valid     = (state_q == ST_DONE);
    assign o_error     = (state_q == ST_ERROR);
    assign o_present   = present_q;
    assign o_err_code  = err_code_q;
    assign o_busy      = busy_q;
endmodule

// File: tb/tb_ds18b20_sequencer.sv
// Scoreboard bench for ds18b20_sequencer: a behavioural DS18B20 block answers
// commands, expected command/result streams are queued and checked by a monitor.
module tb_ds18b20_sequencer;
    import ds18b20_pkg::*;

    localparam int PERIOD  = 50;
    localparam int TIMEOUT = 100;

    typedef struct {
        bit          isErr;
        logic [1:0]  code;
        logic [15:0] raw;
        bit          present;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] temp_raw;
    logic [7:0]  temp_int;
    logic [3:0]  temp_frac;
    logic        valid, present, error, busy;
    logic [1:0]  err_code;

    ds18b20_sequencer_if bus_if ();

    ds18b20_sequencer #(.P_PERIOD_CYC(PERIOD), .P_TIMEOUT_CYC(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_auto      (auto_en),
        .bus         (bus_if),
        .o_temp_raw  (temp_raw),
        .o_temp_int  (temp_int),
        .o_temp_frac (temp_frac),
        .o_valid     (valid),
        .o_present   (present),
        .o_error     (error),
        .o_err_code  (err_code),
        .o_busy      (busy)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [5:0]  cmdQ[$];
    exp_t        resQ[$];
    logic [15:0] lastRaw = 16'h0000;

    bit          cfgDetect = 1'b1;
    logic [15:0] cfgData = 16'h0000;
    int          cfgDelay = 20;
    int          cfgPollDelay = 20;
    bit          forceBusy = 1'b0;
    bit          modelBusy = 1'b0;
    bit          spuriousIrq = 1'b0;

    int          cmdEnCount = 0;
    int          lastCmdCyc = 0;
    int          pollCmdCyc = 0;
    int          lastValidCyc = 0;
    int          gapAtRise = 0;
    bit          prevBusy = 1'b0;

    assign bus_if.busy = forceBusy | modelBusy;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Floor division by 16 of the signed reading, i.e. whole degrees rounded down.
    function automatic logic [7:0] expInt(input logic [15:0] raw);
        int s;
        int f;
        s = int'($signed(raw));
        f = (s >= 0) ? s / 16 : -((-s + 15) / 16);
        return 8'(f);
    endfunction

    function automatic logic [3:0] expFrac(input logic [15:0] raw);
        int s;
        int f;
        s = int'($signed(raw));
        f = (s >= 0) ? s / 16 : -((-s + 15) / 16);
        return 4'(s - f * 16);
    endfunction

    // Behavioural DS18B20 block: answers each command after a programmed delay.
    initial begin
        int       pend;
        logic [5:0] pendCmd;
        pend = 0;
        pendCmd = 6'd0;
        bus_if.irq = 1'b0;
        bus_if.detect = 1'b0;
        bus_if.data = 16'h0000;
        forever begin
            @(negedge clk);
            bus_if.irq = 1'b0;
            bus_if.detect = 1'($urandom_range(0, 1));
            bus_if.data = 16'($urandom);
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus_if.irq = 1'b1;
                        if (pendCmd == CMD_RESET_DETECT) bus_if.detect = cfgDetect;
                        if (pendCmd == CMD_OUTPUT_TEMP) bus_if.data = cfgData;
                    end
                end
                if (spuriousIrq) begin
                    bus_if.irq = 1'b1;
                    bus_if.detect = 1'b0;
                    spuriousIrq = 1'b0;
                end
                if (bus_if.cmd_en) begin
                    pendCmd = bus_if.cmd;
                    pend = (bus_if.cmd == CMD_POLL_WAIT) ? cfgPollDelay : cfgDelay;
                end
            end
            modelBusy = (pend > 0);
        end
    end

    // Monitor: pops expected commands and results whenever the DUT presents them.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.cmd_en) begin
                    cmdEnCount++;
                    lastCmdCyc = cyc;
                    if (bus_if.cmd == CMD_POLL_WAIT) pollCmdCyc = cyc;
                    if (cmdQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL cmd_extra: got cmd 0x%0h, expected no command (cycle %0d)", bus_if.cmd, cyc);
                    end else begin
                        checkOutput("cmd_code", 32'(bus_if.cmd), 32'(cmdQ.pop_front()));
                    end
                end
                if (busy && !prevBusy) gapAtRise = cyc - lastValidCyc;
                prevBusy = busy;
                if (valid || error) begin
                    if (valid) lastValidCyc = cyc;
                    if (resQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL result_extra: got valid=%0b error=%0b, expected no result (cycle %0d)", valid, error, cyc);
                    end else begin
                        e = resQ.pop_front();
                        checkOutput("result_kind", 32'({valid, error}), 32'({~e.isErr, e.isErr}));
                        checkOutput("err_code", 32'(err_code), 32'(e.code));
                        checkOutput("temp_raw", 32'(temp_raw), 32'(e.raw));
                        checkOutput("temp_int", 32'(temp_int), 32'(expInt(e.raw)));
                        checkOutput("temp_frac", 32'(temp_frac), 32'(expFrac(e.raw)));
                        checkOutput("present", 32'(present), 32'(e.present));
                        if (e.code == ERR_TIMEOUT) begin
                            // Timeout counter starts at 0 on the cmd_en cycle and trips on TIMEOUT-1.
                            checkOutput("timeout_latency", 32'(cyc - pollCmdCyc), 32'(TIMEOUT));
                        end
                    end
                end
            end
        end
    end

    // Reference model of one measurement from the command-sequence rules.
    task automatic pushExpected(input bit det, input logic [15:0] data, input bit timedOut);
        exp_t e;
        cmdQ.push_back(CMD_RESET_DETECT);
        if (det) begin
            cmdQ.push_back(CMD_CONVERT_T);
            cmdQ.push_back(CMD_POLL_WAIT);
            if (!timedOut) begin
                cmdQ.push_back(CMD_RESET_DETECT);
                cmdQ.push_back(CMD_READ_SCRATCH);
                cmdQ.push_back(CMD_OUTPUT_TEMP);
            end
        end
        e.isErr = !det || timedOut;
        e.code = !det ? ERR_NO_DEVICE : (timedOut ? ERR_TIMEOUT : ERR_NONE);
        if (!e.isErr) lastRaw = data;
        e.raw = lastRaw;
        e.present = det;
        resQ.push_back(e);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (resQ.size() == 0) break;
            @(posedge clk);
        end
        checkOutput("done_wait", 32'(resQ.size()), 32'd0);
        checkOutput("cmds_left", 32'(cmdQ.size()), 32'd0);
        resQ.delete();
        cmdQ.delete();
        for (int i = 0; i < 300; i++) begin
            if (!modelBusy) break;
            @(posedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit det, input logic [15:0] data, input int delay,
                                 input int pollDelay, input int busyHold);
        bit timedOut;
        int snap;
        int relCyc;
        timedOut = (pollDelay == 0) || (pollDelay >= TIMEOUT);
        cfgDetect = det;
        cfgData = data;
        cfgDelay = delay;
        cfgPollDelay = pollDelay;
        pushExpected(det, data, timedOut);
        if (busyHold > 0) begin
            @(negedge clk);
            forceBusy = 1'b1;
            snap = cmdEnCount;
            pulseStart();
            repeat (busyHold) @(negedge clk);
            checkOutput("busy_hold_no_cmd", 32'(cmdEnCount - snap), 32'd0);
            checkOutput("busy_hold_o_busy", 32'(busy), 32'd1);
            forceBusy = 1'b0;
            relCyc = cyc;
            @(posedge clk);
            @(posedge clk);
            #1;
            checkOutput("busy_release_cmd", 32'(lastCmdCyc - relCyc), 32'd1);
        end else begin
            pulseStart();
        end
        waitDone(4000);
    endtask

    initial begin
        bit det;
        int s;
        int pd;
        int snap;
        $display("[TB] starting ds18b20_sequencer bench");
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd", 32'(bus_if.cmd), 32'd0);
        checkOutput("rst_outputs", 32'({bus_if.cmd_en, valid, error, present, busy, err_code}), 32'd0);
        checkOutput("rst_temp", 32'({temp_raw, temp_int, temp_frac}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        applyStimulus(1'b1, 16'h0191, 20, 20, 0);
        checkOutput("after_done_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 16'h1234, 20, 20, 0);
        applyStimulus(1'b1, 16'h0222, 20, 0, 0);
        applyStimulus(1'b1, 16'hFF5E, 7, 9, 0);
        applyStimulus(1'b1, 16'h0550, 3, 5, 0);
        applyStimulus(1'b1, 16'h07D0, 4, TIMEOUT - 1, 0);
        applyStimulus(1'b1, 16'h0333, 4, TIMEOUT, 0);
        applyStimulus(1'b1, 16'hFC90, 6, 6, 30);

        // Periodic mode: two measurements, with a manual start thrown in mid-flight.
        cfgDetect = 1'b1;
        cfgData = 16'h0123;
        cfgDelay = 5;
        cfgPollDelay = 8;
        pushExpected(1'b1, 16'h0123, 1'b0);
        pushExpected(1'b1, 16'h0123, 1'b0);
        @(negedge clk);
        auto_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (busy) break;
            @(posedge clk);
        end
        repeat (10) @(negedge clk);
        pulseStart();
        for (int i = 0; i < 4000; i++) begin
            if (resQ.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        auto_en = 1'b0;
        // Start is decided on the PERIOD-th idle cycle; o_busy shows it one cycle later.
        checkOutput("auto_period", 32'(gapAtRise), 32'(PERIOD + 1));
        waitDone(10);

        snap = cmdEnCount;
        @(negedge clk);
        spuriousIrq = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("idle_irq_busy", 32'(busy), 32'd0);
        checkOutput("idle_irq_cmd", 32'(cmdEnCount - snap), 32'd0);

        for (int n = 0; n < 8; n++) begin
            det = ($urandom_range(0, 4) != 0);
            s = int'($urandom_range(0, 2880)) - 880;
            pd = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
            applyStimulus(det, 16'(s), int'($urandom_range(2, 25)), pd, 0);
        end

        // Asynchronous reset in the middle of the CONVERT_T wait.
        applyStimulus(1'b1, 16'h0191, 4, 4, 0);
        cfgDelay = 20;
        cfgPollDelay = 20;
        pushExpected(1'b1, 16'h0191, 1'b0);
        snap = cmdEnCount;
        pulseStart();
        for (int i = 0; i < 200; i++) begin
            if (cmdEnCount >= snap + 2) break;
            @(posedge clk);
        end
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_cmd", 32'(bus_if.cmd), 32'd0);
        checkOutput("async_rst_outputs", 32'({bus_if.cmd_en, valid, error, present, busy, err_code}), 32'd0);
        checkOutput("async_rst_temp", 32'({temp_raw, temp_int, temp_frac}), 32'd0);
        cmdQ.delete();
        resQ.delete();
        lastRaw = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 16'h0550, 5, 5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
